// File: rtl/sevenseg_pkg.sv
// Shared segment constants and the digit-to-pattern decode used by sevenseg.
// Patterns are active-high in {a,b,c,d,e,f,g} order, a at bit 6.
package sevenseg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h7E;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h33;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h5F;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h70;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h7B;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h1F;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h4E;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h3D;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h47;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Any code not matched (including X/Z in simulation) falls to blank.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d, input bit hex_en);
    logic [SEG_W-1:0] pat;
    pat = SEG_BLANK;
    case (d)
      4'd0:  pat = SEG_0;
      4'd1:  pat = SEG_1;
      4'd2:  pat = SEG_2;
      4'd3:  pat = SEG_3;
      4'd4:  pat = SEG_4;
      4'd5:  pat = SEG_5;
      4'd6:  pat = SEG_6;
      4'd7:  pat = SEG_7;
      4'd8:  pat = SEG_8;
      4'd9:  pat = SEG_9;
      4'd10: pat = hex_en ? SEG_A : SEG_BLANK;
      4'd11: pat = hex_en ? SEG_B : SEG_BLANK;
      4'd12: pat = hex_en ? SEG_C : SEG_BLANK;
      4'd13: pat = hex_en ? SEG_D : SEG_BLANK;
      4'd14: pat = hex_en ? SEG_E : SEG_BLANK;
      4'd15: pat = hex_en ? SEG_F : SEG_BLANK;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sevenseg_rom.sv
// Combinational digit decode; polarity and registering live in the top.
import sevenseg_pkg::*;

module sevenseg_rom #(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0]       in,
  output logic [SEG_W-1:0] pattern
);

  always_comb begin
    pattern = seg_decode(in, HEX_EN);
  end

endmodule

// File: rtl/sevenseg.sv
// Registered 7-segment driver: decode, optional inversion for common-anode
// parts, then an async-reset output register that resets to blank.
import sevenseg_pkg::*;

module sevenseg #(
  parameter bit HEX_EN     = 1'b0,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in,
  output logic [SEG_W-1:0] out
);

  localparam logic [SEG_W-1:0] POL_MASK  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [SEG_W-1:0] RST_VALUE = SEG_BLANK ^ POL_MASK;

  logic [SEG_W-1:0] pattern;
  logic [SEG_W-1:0] next_out;

  sevenseg_rom #(
    .HEX_EN (HEX_EN)
  ) u_rom (
    .in      (in),
    .pattern (pattern)
  );

  // Inversion is applied before the register so out never shows the raw pattern.
  always_comb begin
    next_out = pattern ^ POL_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= RST_VALUE;
    end else begin
      out <= next_out;
    end
  end

endmodule

// File: tb/tb_sevenseg.sv
// Bench for sevenseg: four instances cover every HEX_EN / ACTIVE_LOW combination,
// checked against spelled-out segment sets and a literal decode table.
module tb_sevenseg;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic [6:0] out_dec, out_hex, out_al, out_alh;

  int total;
  int passed;

  logic [27:0] exp_q[$];
  string       seg_str[16];

  typedef struct {
    logic [3:0] din;
    logic [6:0] exp_dec;
    logic [6:0] exp_hex;
  } vec_t;

  vec_t vecs[16];

  sevenseg #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b0)) u_dec (.clk(clk), .rst_n(rst_n), .in(in), .out(out_dec));
  sevenseg #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b0)) u_hex (.clk(clk), .rst_n(rst_n), .in(in), .out(out_hex));
  sevenseg #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b1)) u_al  (.clk(clk), .rst_n(rst_n), .in(in), .out(out_al));
  sevenseg #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b1)) u_alh (.clk(clk), .rst_n(rst_n), .in(in), .out(out_alh));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lit segments named by letter, mapped a->bit6 .. g->bit0.
  function automatic logic [6:0] model(input logic [3:0] d, input bit hex_en, input bit active_low);
    logic [6:0] pat;
    string      s;
    pat = 7'h00;
    if (d < 10 || hex_en) begin
      s = seg_str[d];
      for (int i = 0; i < s.len(); i++) pat[6 - (s[i] - 8'h61)] = 1'b1;
    end
    return active_low ? ~pat : pat;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %02h expected %02h (time %0t)", name, act, exp, $time);
  endtask

  task automatic check_all(input string name, input logic [6:0] e_dec, input logic [6:0] e_hex);
    check({name, "/dec"}, out_dec, e_dec);
    check({name, "/hex"}, out_hex, e_hex);
    check({name, "/al"},  out_al,  ~e_dec);
    check({name, "/alh"}, out_alh, ~e_hex);
  endtask

  // driver: change in away from the edge, then sample just after the next edge
  task automatic apply(input logic [3:0] d);
    @(negedge clk);
    in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    seg_str = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    vecs = '{
      '{4'd0,  7'h7E, 7'h7E}, '{4'd1,  7'h30, 7'h30}, '{4'd2,  7'h6D, 7'h6D},
      '{4'd3,  7'h79, 7'h79}, '{4'd4,  7'h33, 7'h33}, '{4'd5,  7'h5B, 7'h5B},
      '{4'd6,  7'h5F, 7'h5F}, '{4'd7,  7'h70, 7'h70}, '{4'd8,  7'h7F, 7'h7F},
      '{4'd9,  7'h7B, 7'h7B}, '{4'd10, 7'h00, 7'h77}, '{4'd11, 7'h00, 7'h1F},
      '{4'd12, 7'h00, 7'h4E}, '{4'd13, 7'h00, 7'h3D}, '{4'd14, 7'h00, 7'h4F},
      '{4'd15, 7'h00, 7'h47}
    };

    // Reset held while clock runs and input is non-blank.
    rst_n = 1'b0;
    in    = 4'd8;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_hold", 7'h00, 7'h00);

    // Released between edges: output stays blank until the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("release_pre_edge", 7'h00, 7'h00);
    @(posedge clk);
    #1;
    check_all("release_first_edge", 7'h7F, 7'h7F);

    // Table sweep across all 16 codes.
    foreach (vecs[i]) begin
      apply(vecs[i].din);
      check_all($sformatf("table_%0d", vecs[i].din), vecs[i].exp_dec, vecs[i].exp_hex);
    end

    // 9 -> 10 -> 0 in decimal mode.
    apply(4'd9);
    check("seq_9", out_dec, 7'h7B);
    apply(4'd10);
    check("seq_10", out_dec, 7'h00);
    apply(4'd0);
    check("seq_0", out_dec, 7'h7E);

    // Mid-cycle input change must not reach out before the edge.
    apply(4'd3);
    #2;
    in = 4'd8;
    #1;
    check_all("latency_hold", 7'h79, 7'h79);
    @(posedge clk);
    #1;
    check_all("latency_update", 7'h7F, 7'h7F);

    // Constant input gives constant output.
    in = 4'd5;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("hold5_%0d", c), 7'h5B, 7'h5B);
    end

    // Reset asserted between edges blanks immediately.
    apply(4'd12);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 7'h00, 7'h00);
    @(posedge clk);
    #1;
    check_all("async_reset_held", 7'h00, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized stimulus against the letter-set model via expected queue.
    for (int r = 0; r < 200; r++) begin
      logic [3:0] d;
      logic [27:0] e;
      d = 4'($urandom_range(0, 15));
      exp_q.push_back({model(d, 1'b0, 1'b0), model(d, 1'b1, 1'b0),
                       model(d, 1'b0, 1'b1), model(d, 1'b1, 1'b1)});
      apply(d);
      e = exp_q.pop_front();
      check($sformatf("rand_%0d_in%0d/dec", r, d), out_dec, e[27:21]);
      check($sformatf("rand_%0d_in%0d/hex", r, d), out_hex, e[20:14]);
      check($sformatf("rand_%0d_in%0d/al",  r, d), out_al,  e[13:7]);
      check($sformatf("rand_%0d_in%0d/alh", r, d), out_alh, e[6:0]);
    end

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
